// File: rtl/adder_err_pkg.sv
// Shared types and constants for the adder error-statistics monitor.
// The optional signed-bias output is enabled by defining ADDER_ERR_BIAS_EN.
package adder_err_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int RES_W     = DEF_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // The summed ED can reach (2^(width+1)-1) * 2^samples_log2, so this width never overflows.
    function automatic int sum_width(input int width, input int samples_log2);
        return width + 1 + samples_log2;
    endfunction

endpackage

// File: rtl/abs_diff33.sv
// Registered error-distance stage: |approx - exact| without wrap, one cycle of latency.
// With ADDER_ERR_BIAS_EN it also flags approx < exact so the bias can be signed.
module abs_diff33
    import adder_err_pkg::*;
#(
    parameter int W = RES_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    input  logic [W-1:0] approx,
    input  logic [W-1:0] exact,
    output logic [W-1:0] ed,
    output logic         ed_valid
`ifdef ADDER_ERR_BIAS_EN
    ,
    output logic         ed_neg
`endif
);

    logic approx_lt;

    assign approx_lt = (approx < exact);

    // NOTE: only the valid flag is reset; ed is qualified by ed_valid, so the wide datapath
    // register needs no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ed_valid <= 1'b0;
        end else begin
            ed_valid <= valid;
        end
    end

    always_ff @(posedge clk) begin
        if (valid) begin
            ed <= approx_lt ? (exact - approx) : (approx - exact);
        end
    end

`ifdef ADDER_ERR_BIAS_EN
    always_ff @(posedge clk) begin
        if (valid) begin
            ed_neg <= approx_lt;
        end
    end
`endif

endmodule

// File: rtl/adder_error_monitor32.sv
// Error-statistics collector for approximate 32-bit adders: error count, max ED and summed ED
// over a 2^SAMPLES_LOG2 sample window. Define ADDER_ERR_BIAS_EN to add the signed bias_o output.
module adder_error_monitor32
    import adder_err_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int SAMPLES_LOG2 = 10,
    parameter int SUM_W        = sum_width(WIDTH, SAMPLES_LOG2)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [WIDTH:0]          approx_i,
    input  logic [WIDTH:0]          exact_i,
    output logic                    done_o,
    output logic [SAMPLES_LOG2:0]   err_count_o,
    output logic [WIDTH:0]          max_ed_o,
    output logic [SUM_W-1:0]        sum_ed_o
`ifdef ADDER_ERR_BIAS_EN
    ,
    output logic signed [SUM_W:0]   bias_o
`endif
);

    localparam int RW = WIDTH + 1;

    state_t                  state;
    logic [SAMPLES_LOG2-1:0] sample_cnt;
    logic                    accept;
    logic                    start_ok;

    logic                    sample_valid;
    logic [RW-1:0]           approx_q;
    logic [RW-1:0]           exact_q;

    logic [RW-1:0]           ed;
    logic                    ed_valid;
    logic [SUM_W-1:0]        ed_ext;
    logic                    ed_nz;
`ifdef ADDER_ERR_BIAS_EN
    logic                    ed_neg;
`endif

    assign accept   = valid_i && ready_o;
    assign start_ok = start_i && ((state == IDLE) || (state == DONE));
    assign ed_ext   = SUM_W'(ed);
    assign ed_nz    = (ed != '0);

    // Control FSM; ready_o and done_o are registered alongside the state.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            ready_o    <= 1'b0;
            done_o     <= 1'b0;
            sample_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        state      <= RUN;
                        ready_o    <= 1'b1;
                        sample_cnt <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        sample_cnt <= sample_cnt + 1'b1;
                        if (sample_cnt == '1) begin
                            state   <= DRAIN;
                            ready_o <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    state <= DONE;
                end
                DONE: begin
                    if (start_i) begin
                        state      <= RUN;
                        ready_o    <= 1'b1;
                        done_o     <= 1'b0;
                        sample_cnt <= '0;
                    end else begin
                        // Raised one edge after entering DONE, when the last ED has been summed.
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

    // Input capture stage: accepted operands are held for the ED stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= accept;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            approx_q <= approx_i;
            exact_q  <= exact_i;
        end
    end

    abs_diff33 #(
        .W(RW)
    ) u_abs_diff (
        .clk      (clk_i),
        .rst      (rst_i),
        .valid    (sample_valid),
        .approx   (approx_q),
        .exact    (exact_q),
        .ed       (ed),
        .ed_valid (ed_valid)
`ifdef ADDER_ERR_BIAS_EN
        ,
        .ed_neg   (ed_neg)
`endif
    );

    // Accumulators; a window restart takes priority over a straggling ED.
    always_ff @(posedge clk_i) begin
        if (rst_i || start_ok) begin
            err_count_o <= '0;
            max_ed_o    <= '0;
            sum_ed_o    <= '0;
        end else if (ed_valid) begin
            err_count_o <= err_count_o + {{SAMPLES_LOG2{1'b0}}, ed_nz};
            if (ed > max_ed_o) begin
                max_ed_o <= ed;
            end
            sum_ed_o <= sum_ed_o + ed_ext;
        end
    end

`ifdef ADDER_ERR_BIAS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i || start_ok) begin
            bias_o <= '0;
        end else if (ed_valid) begin
            if (ed_neg) begin
                bias_o <= bias_o - $signed({1'b0, ed_ext});
            end else begin
                bias_o <= bias_o + $signed({1'b0, ed_ext});
            end
        end
    end
`endif

endmodule
